// File: rtl/rf_arb_pkg.sv
// Shared constants, the write-request record and the grant-select helper
// for the register-file write-back arbiter.
package rf_arb_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // One-hot grant {req1, req0}. The oldest entry wins a same-register
    // conflict. Otherwise the requester that was not granted last wins.
    function automatic logic [1:0] select_grant(
        input logic full0,
        input logic full1,
        input logic same_addr,
        input logic old1,
        input logic rr_last
    );
        logic [1:0] sel;
        if (full0 && full1) begin
            if (same_addr)
                sel = old1 ? 2'b10 : 2'b01;
            else
                sel = rr_last ? 2'b01 : 2'b10;
        end else begin
            sel = {full1, full0};
        end
        return sel;
    endfunction
endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for a pending register-file write.
module wb_hold_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    logic              full_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;

    // A load on the same edge as a clear is a reload and must keep the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_reg <= 1'b0;
        end else if (load) begin
            full_reg <= 1'b1;
        end else if (clear) begin
            full_reg <= 1'b0;
        end
        if (load) begin
            addr_reg <= load_addr;
            data_reg <= load_data;
        end
    end

    assign full = full_reg;
    assign addr = addr_reg;
    assign data = data_reg;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester write-back arbiter for the register file's single write
// port, with per-requester holding buffers and a read-address bypass.
module rf_wb_arbiter #(
    parameter int DATA_W = rf_arb_pkg::DATA_W,
    parameter int ADDR_W = rf_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              byp_a_hit,
    output logic [DATA_W-1:0] byp_a_data,
    output logic              byp_b_hit,
    output logic [DATA_W-1:0] byp_b_data,
    output logic              zero_drop
);
    import rf_arb_pkg::select_grant;
    import rf_arb_pkg::ZERO_REG;

    logic [1:0]        valid, ready, full, grant, accept, load, zero_hit;
    logic [ADDR_W-1:0] in_addr  [2];
    logic [DATA_W-1:0] in_data  [2];
    logic [ADDR_W-1:0] buf_addr [2];
    logic [DATA_W-1:0] buf_data [2];
    logic [ADDR_W-1:0] rd_addr  [2];
    logic [1:0]        byp_hit;
    logic [DATA_W-1:0] byp_data [2];
    logic              rr_last_reg, old1_reg, zero_drop_reg;

    assign valid      = {req1_valid, req0_valid};
    assign in_addr[0] = req0_addr;
    assign in_addr[1] = req1_addr;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;
    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    assign grant = select_grant(full[0], full[1], buf_addr[0] == buf_addr[1],
                                old1_reg, rr_last_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign ready[gi]    = ~full[gi] | grant[gi];
            assign accept[gi]   = valid[gi] & ready[gi];
            assign zero_hit[gi] = accept[gi] & (in_addr[gi] == ADDR_W'(ZERO_REG));
            assign load[gi]     = accept[gi] & ~zero_hit[gi];

            wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf (
                .clk       (clk),
                .reset     (reset),
                .load      (load[gi]),
                .clear     (grant[gi]),
                .load_addr (in_addr[gi]),
                .load_data (in_data[gi]),
                .full      (full[gi]),
                .addr      (buf_addr[gi]),
                .data      (buf_data[gi])
            );
        end

        // Per read port: when both buffers match, the newer one (not old1's pick) wins.
        for (gi = 0; gi < 2; gi++) begin : g_byp
            logic hit0, hit1, take1;
            assign hit0  = full[0] & (buf_addr[0] == rd_addr[gi]) & (rd_addr[gi] != ADDR_W'(ZERO_REG));
            assign hit1  = full[1] & (buf_addr[1] == rd_addr[gi]) & (rd_addr[gi] != ADDR_W'(ZERO_REG));
            assign take1 = hit1 & (~hit0 | ~old1_reg);
            assign byp_hit[gi]  = hit0 | hit1;
            assign byp_data[gi] = take1 ? buf_data[1] : (hit0 ? buf_data[0] : '0);
        end
    endgenerate

    // Loading a buffer makes it the newest; a simultaneous double load leaves buffer 0 older.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_reg   <= 1'b1;
            old1_reg      <= 1'b0;
            zero_drop_reg <= 1'b0;
        end else begin
            zero_drop_reg <= |zero_hit;
            if (|grant)
                rr_last_reg <= grant[1];
            if (load[1])
                old1_reg <= 1'b0;
            else if (load[0])
                old1_reg <= 1'b1;
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign wr_en      = (|grant) & ~reset;
    assign wr_addr    = grant[1] ? buf_addr[1] : buf_addr[0];
    assign wr_data    = grant[1] ? buf_data[1] : buf_data[0];
    assign byp_a_hit  = byp_hit[0];
    assign byp_a_data = byp_data[0];
    assign byp_b_hit  = byp_hit[1];
    assign byp_b_data = byp_data[1];
    assign zero_drop  = zero_drop_reg;
endmodule
